// File: rtl/queue_drain.sv
// queue_drain: pops words from the 8-entry queue (deq/dout/empty, 1-cycle read
// latency) and re-presents them as a valid/ready stream through a 2-entry
// skid buffer, counting every accepted output word.
module queue_drain #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned CNTWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                q_empty,
  output logic                q_deq,
  input  logic [DWIDTH-1:0]   q_dout,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DWIDTH-1:0]   m_data,
  output logic [CNTWIDTH-1:0] words_out,
  output logic                busy
);

  // Width of the "committed words" sum (occupancy + in-flight read).
  localparam int unsigned LVLW = 3;

  // Encoding equals buffer occupancy so the state can feed the level sum.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_pend;
  logic [DWIDTH-1:0]   r_head;
  logic [DWIDTH-1:0]   r_tail;
  logic [CNTWIDTH-1:0] r_words;

  logic                w_pop;
  logic                w_cap;
  logic                w_deq;
  logic [1:0]          w_occ;
  logic [LVLW-1:0]     w_level;
  logic                w_head_ld_dout;
  logic                w_head_ld_tail;
  logic                w_tail_ld_dout;

  assign w_pop = m_valid & m_ready;
  assign w_cap = r_pend;
  assign w_occ = r_state;

  // Words held or already requested after this edge's pop; must stay below 2.
  assign w_level = LVLW'(w_occ) + LVLW'(r_pend) - LVLW'(w_pop);

  // Dequeue request; combinational from m_ready so a pop frees a slot at once.
  assign w_deq = en & ~q_empty & ~rst & (w_level < LVLW'(2));
  assign q_deq = w_deq;

  // State register: buffer occupancy plus the read-in-flight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_deq;
    end
  end

  // Next occupancy and buffer write steering; capture lands after the pop.
  always_comb begin
    w_state_nxt    = r_state;
    w_head_ld_dout = 1'b0;
    w_head_ld_tail = 1'b0;
    w_tail_ld_dout = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_cap) begin
          w_state_nxt    = S_ONE;
          w_head_ld_dout = 1'b1;
        end
      end
      S_ONE: begin
        if (w_cap && !w_pop) begin
          w_state_nxt    = S_TWO;
          w_tail_ld_dout = 1'b1;
        end else if (!w_cap && w_pop) begin
          w_state_nxt    = S_EMPTY;
        end else if (w_cap && w_pop) begin
          w_head_ld_dout = 1'b1;
        end
      end
      S_TWO: begin
        if (w_pop) begin
          w_state_nxt    = S_ONE;
          w_head_ld_tail = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Buffer storage: head is the oldest word, tail the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_head_ld_dout) begin
        r_head <= q_dout;
      end else if (w_head_ld_tail) begin
        r_head <= r_tail;
      end
      if (w_tail_ld_dout) begin
        r_tail <= q_dout;
      end
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNTWIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words <= '0;
    end else if (w_pop) begin
      r_words <= r_words + CNTWIDTH'(1);
    end
  end

  assign m_valid   = (r_state != S_EMPTY);
  assign m_data    = r_head;
  assign words_out = r_words;
  assign busy      = r_pend | (r_state != S_EMPTY);

  // A capture into a full buffer without a pop would lose a word.
  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    !((r_state == S_TWO) && r_pend && !w_pop));

endmodule

// File: tb/tb_queue_drain.sv
// Bench for queue_drain: an 8-entry queue model feeds the DUT; a word-level
// model (what is buffered, what is in flight) predicts every output each cycle.
module tb_queue_drain;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          en       = 1'b0;
  logic          q_empty  = 1'b1;
  logic          q_deq;
  logic [DW-1:0] q_dout   = '0;
  logic          m_valid;
  logic          m_ready  = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] words_out;
  logic          busy;

  // Upstream queue model
  logic          push_en  = 1'b0;
  logic [DW-1:0] push_val = '0;
  logic [DW-1:0] bq[$];
  logic [DW-1:0] pop_word;

  // Reference model and logs
  logic [DW-1:0] mb[$];
  bit            m_infl;
  logic [DW-1:0] m_infl_val;
  int unsigned   m_cnt;
  int unsigned   cyc;
  int unsigned   n_deq;
  logic [DW-1:0] dlv_data[$];
  int unsigned   dlv_cyc[$];
  int unsigned   deq_cyc[$];

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] w[8];

  queue_drain #(.DWIDTH(DW), .CNTWIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .q_empty   (q_empty),
    .q_deq     (q_deq),
    .q_dout    (q_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .words_out (words_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Queue: dout registered on the deq edge, empty registered after the edge.
  always @(posedge clk) begin
    if (q_deq && bq.size() != 0) begin
      pop_word = bq.pop_front();
      q_dout  <= pop_word;
    end
    if (push_en) bq.push_back(push_val);
    q_empty <= (bq.size() == 0);
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predict outputs just before the edge, then advance the model across it.
  task automatic check_cycle();
    bit exp_valid;
    bit exp_pop;
    bit exp_deq;
    int lvl;
    if (rst) begin
      mb.delete();
      m_infl = 1'b0;
      m_cnt  = 0;
    end
    exp_valid = (mb.size() != 0);
    exp_pop   = exp_valid && m_ready;
    lvl       = mb.size() + (m_infl ? 1 : 0) - (exp_pop ? 1 : 0);
    exp_deq   = en && !q_empty && !rst && (lvl < 2);
    cmp("m_valid", 64'(m_valid), 64'(exp_valid));
    if (exp_valid) cmp("m_data", 64'(m_data), 64'(mb[0]));
    cmp("q_deq", 64'(q_deq), 64'(exp_deq));
    cmp("busy", 64'(busy), 64'(m_infl || exp_valid));
    cmp("words_out", 64'(words_out), 64'(CW'(m_cnt)));
    if (q_deq) begin
      n_deq++;
      deq_cyc.push_back(cyc);
    end
    if (m_valid && m_ready) begin
      dlv_data.push_back(m_data);
      dlv_cyc.push_back(cyc);
    end
    if (!rst) begin
      if (exp_pop) begin
        void'(mb.pop_front());
        m_cnt++;
      end
      if (m_infl) mb.push_back(m_infl_val);
      m_infl = exp_deq && (bq.size() != 0);
      if (m_infl) m_infl_val = bq[0];
    end
    cyc++;
  endtask

  task automatic tick();
    #4;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    push_en  = 1'b1;
    push_val = v;
    tick();
    push_en  = 1'b0;
  endtask

  task automatic clear_logs();
    dlv_data.delete();
    dlv_cyc.delete();
    deq_cyc.delete();
    n_deq = 0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    push_en = 1'b0;
    run(2);
    rst = 1'b0;
    clear_logs();
    tick();
  endtask

  task automatic fill_words();
    for (int i = 0; i < 8; i++) w[i] = $urandom;
  endtask

  initial begin
    cyc = 0;
    clear_logs();
    run(2);
    cmp("reset words_out", 64'(words_out), 64'd0);
    cmp("reset m_valid", 64'(m_valid), 64'd0);
    do_reset();

    // Reset with one word buffered and one read in flight
    fill_words();
    for (int i = 0; i < 5; i++) push_word(w[i]);
    en = 1'b1;
    run(2);
    rst = 1'b1;
    #1;
    cmp("t1 m_valid in reset", 64'(m_valid), 64'd0);
    cmp("t1 q_deq in reset", 64'(q_deq), 64'd0);
    cmp("t1 busy in reset", 64'(busy), 64'd0);
    tick();
    cmp("t1 words_out after reset", 64'(words_out), 64'd0);
    rst     = 1'b0;
    m_ready = 1'b1;
    clear_logs();
    run(10);
    cmp("t1 delivered count", 64'(dlv_data.size()), 64'd3);
    if (dlv_data.size() == 3)
      for (int i = 0; i < 3; i++) cmp("t1 word after reset", 64'(dlv_data[i]), 64'(w[i+2]));
    cmp("t1 words_out", 64'(words_out), 64'd3);

    // Full-rate drain of 8 words
    do_reset();
    fill_words();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(w[i]);
    en = 1'b1;
    run(14);
    cmp("t2 deq pulses", 64'(n_deq), 64'd8);
    cmp("t2 delivered count", 64'(dlv_data.size()), 64'd8);
    if (dlv_data.size() == 8 && deq_cyc.size() == 8)
      for (int i = 0; i < 8; i++) begin
        cmp("t2 data order", 64'(dlv_data[i]), 64'(w[i]));
        cmp("t2 deq back-to-back", 64'(deq_cyc[i]), 64'(deq_cyc[0] + i));
        cmp("t2 latency", 64'(dlv_cyc[i]), 64'(deq_cyc[i] + 2));
      end
    cmp("t2 words_out", 64'(words_out), 64'd8);

    // Stalled consumer: buffer fills to two, then drains gap-free
    do_reset();
    fill_words();
    for (int i = 0; i < 8; i++) push_word(w[i]);
    en = 1'b1;
    run(10);
    cmp("t3 deq while stalled", 64'(n_deq), 64'd2);
    cmp("t3 m_valid held", 64'(m_valid), 64'd1);
    cmp("t3 m_data held", 64'(m_data), 64'(w[0]));
    m_ready = 1'b1;
    run(14);
    cmp("t3 deq total", 64'(n_deq), 64'd8);
    cmp("t3 delivered count", 64'(dlv_data.size()), 64'd8);
    if (dlv_data.size() == 8)
      for (int i = 0; i < 8; i++) begin
        cmp("t3 data order", 64'(dlv_data[i]), 64'(w[i]));
        cmp("t3 no gaps", 64'(dlv_cyc[i]), 64'(dlv_cyc[0] + i));
      end
    cmp("t3 words_out", 64'(words_out), 64'd8);

    // Single word with toggling ready
    do_reset();
    fill_words();
    push_word(w[0]);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    cmp("t4 deq pulses", 64'(n_deq), 64'd1);
    cmp("t4 delivered count", 64'(dlv_data.size()), 64'd1);
    if (dlv_data.size() == 1) cmp("t4 word", 64'(dlv_data[0]), 64'(w[0]));
    cmp("t4 q_deq idle", 64'(q_deq), 64'd0);

    // Enable dropped right after a deq
    do_reset();
    fill_words();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(w[i]);
    en = 1'b1;
    tick();
    en = 1'b0;
    run(6);
    cmp("t5 deq while disabled", 64'(n_deq), 64'd1);
    cmp("t5 delivered count", 64'(dlv_data.size()), 64'd1);
    if (dlv_data.size() == 1) cmp("t5 in-flight word", 64'(dlv_data[0]), 64'(w[0]));
    cmp("t5 busy idle", 64'(busy), 64'd0);
    en = 1'b1;
    run(10);
    cmp("t5 deq total", 64'(n_deq), 64'd5);
    cmp("t5 delivered total", 64'(dlv_data.size()), 64'd5);
    if (dlv_data.size() == 5)
      for (int i = 0; i < 5; i++) cmp("t5 data order", 64'(dlv_data[i]), 64'(w[i]));

    // Counter wrap after 0xFFFF accepted words
    do_reset();
    m_ready = 1'b1;
    en      = 1'b1;
    for (int i = 0; i < 65535; i++) push_word($urandom);
    run(8);
    cmp("t6 words_out at max", 64'(words_out), 64'hFFFF);
    push_word($urandom);
    run(8);
    cmp("t6 words_out wrapped", 64'(words_out), 64'h0000);

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 2) != 0);
      push_en  = (bq.size() < 8) && ($urandom_range(0, 1) != 0);
      push_val = $urandom;
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst      = 1'b0;
    push_en  = 1'b0;
    en       = 1'b1;
    m_ready  = 1'b1;
    run(24);
    cmp("rand drained m_valid", 64'(m_valid), 64'd0);
    cmp("rand drained busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
